cache_refill_arbiter: RTL and testbench
=======================================

Name: cache_refill_arbiter

Overview:
- Shares one AXI4 read channel (AR/R) between the icache and dcache refill ports.
- Accepts a miss request (rd_req/rd_addr) from either cache and issues one 16-beat × 32-bit INCR burst.
- Assembles the beats into a 512-bit line, then pulses reload to the winning cache with cacheline_new.
- Sits between the L1 caches and the AXI master interface; one burst outstanding at a time.

Parameters:
- LINE_BEATS, 16, beats per cache line (512/32); arlen = LINE_BEATS-1.
- ICACHE_ID, 4'd0, arid used for icache refills.
- DCACHE_ID, 4'd1, arid used for dcache refills.

Ports:
- clk  input  1  clock
- resetn  input  1  reset
- icache_rd_req  input  1  icache miss request, held high until serviced
- icache_rd_addr  input  32  icache miss line address
- icache_reload  output  1  one-cycle line-valid pulse to icache
- icache_cacheline_new  output  512  refilled line to icache
- dcache_rd_req  input  1  dcache miss request, held high until serviced
- dcache_rd_addr  input  32  dcache miss line address
- dcache_reload  output  1  one-cycle line-valid pulse to dcache
- dcache_cacheline_new  output  512  refilled line to dcache
- arid  output  4  read ID
- araddr  output  32  burst address
- arlen  output  8  constant LINE_BEATS-1 (8'd15)
- arsize  output  3  constant 3'b010
- arburst  output  2  constant 2'b01 (INCR)
- arvalid  output  1  AR valid
- arready  input  1  AR ready
- rid  input  4  read ID (ignored)
- rdata  input  32  read data
- rresp  input  2  read response (ignored)
- rlast  input  1  last beat
- rvalid  input  1  R valid
- rready  output  1  R ready

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk.
  - state=IDLE; arvalid, rready, both reload outputs = 0; araddr=0; arid=0.
  - Line buffer, beat counter and last_grant = 0.
  - Reset mid-burst aborts immediately; the interconnect shares this reset.
- FSM:
  - IDLE: sample requests.
    - If any rd_req is high, latch the winner, latch araddr = {addr[31:6],6'b0} and arid, go to AR.
    - Otherwise stay in IDLE.
  - AR: arvalid=1; araddr/arid stable.
    - On arvalid&arready, go to R and clear the beat counter.
  - R: rready=1.
    - Each rvalid beat writes rdata to buffer[beat*32 +: 32] (beat 0 → bits 31:0) and increments the 4-bit counter.
    - On rvalid&rlast, go to DONE.
    - rlast is authoritative; on an early rlast, unwritten words keep their old contents.
  - DONE: reload of the latched winner = 1 for exactly this cycle; go to IDLE.
- cacheline_new outputs are driven continuously from the buffer, so the data is valid in the reload cycle and held afterwards.
- Requests are sampled only in IDLE; changes on rd_req/rd_addr outside IDLE are ignored.
  - After DONE the requester's tag is written at the DONE edge, so its rd_req is already low when IDLE samples.
- Arbitration with both requests high: dcache wins (fixed priority).
- Latency: req sampled in IDLE at cycle 0 → arvalid at cycle 1.
  - With arready=1 and back-to-back rvalid, beats land at cycles 2–17 and reload pulses at cycle 18.
- rresp and rid are not checked; no error reporting.

Optional Feature:
- REFILL_RR_ARB_EN defined: round-robin arbitration.
  - last_grant updates on each grant.
  - When both caches request, the cache not granted last wins.
  - A single requester always wins.
- Undefined: fixed dcache priority; last_grant is not implemented.

Test Plan:
- icache_rd_req=1, addr 0x1FC0_0123, arready=1, 16 back-to-back beats of data 0..15:
  - araddr=0x1FC0_0100, arid=0, arlen=15, arsize=2, arburst=1 at cycle 1.
  - icache_reload=1 only at cycle 18.
  - icache_cacheline_new[31:0]=0, [511:480]=15.
  - dcache_reload stays 0.
- Both requests high in the same IDLE cycle (macro off): dcache is served first with arid=1; icache is served next.
  - Macro on, after a prior dcache grant: icache is served first.
- arready low for 3 cycles: arvalid and araddr stay stable; R phase starts only after the handshake.
- rvalid with 2-cycle gaps between beats: beats are placed in order, no duplicates, reload after rlast.
- resetn=0 asserted at beat 7:
  - Next cycle: state IDLE, rready=0, both reloads 0, buffer=0.
  - A new request after reset completes normally.
- Early rlast on beat 3: DONE follows, reload pulses, words 4–15 retain prior line data.

Source files
------------

// File: rtl/cache_refill_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_refill_arbiter_if
// AXI4 read-address / read-data channel bundle used by the cache refill arbiter.
//   master : arbiter side (drives AR payload, arvalid, rready)
//   slave  : memory / interconnect side (drives arready and the R channel)
// Signals:
//   arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0],
//   arvalid, arready, rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid, rready
// -----------------------------------------------------------------------------
interface cache_refill_arbiter_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_refill_arbiter
// Shares one AXI4 read channel between the icache and dcache refill ports.
// A miss request is turned into a single LINE_BEATS x 32-bit INCR burst; the
// beats are assembled into a line buffer and the winning cache receives a
// one-cycle reload pulse. Only one burst is outstanding at a time.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   icache_rd_req/rd_addr       icache miss request (held until serviced)
//   icache_reload               one-cycle line-valid pulse to icache
//   icache_cacheline_new        refilled line (continuously driven from buffer)
//   dcache_*                    same set for the dcache
//   axi (master modport)        AXI4 AR/R channel
//
// Build option:
//   REFILL_RR_ARB_EN  defined   -> round-robin arbitration between the caches
//                     undefined -> fixed priority, dcache wins
// -----------------------------------------------------------------------------
module cache_refill_arbiter #(
   parameter int          LINE_BEATS = 16,
   parameter logic [3:0]  ICACHE_ID  = 4'd0,
   parameter logic [3:0]  DCACHE_ID  = 4'd1
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       icache_rd_req,
   input  logic [31:0]                icache_rd_addr,
   output logic                       icache_reload,
   output logic [LINE_BEATS*32-1:0]   icache_cacheline_new,
   input  logic                       dcache_rd_req,
   input  logic [31:0]                dcache_rd_addr,
   output logic                       dcache_reload,
   output logic [LINE_BEATS*32-1:0]   dcache_cacheline_new,
   cache_refill_arbiter_if.master     axi
);
   localparam int CNT_W = $clog2(LINE_BEATS);
   localparam int OFS_W = CNT_W + 2;
   // clears the byte offset inside the line
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFS_W) - 32'd1);

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

   state_t             state_reg, state_next;
   logic               winner_dcache_reg;
   logic               grant_dcache;
   logic               any_req;
   logic [31:0]        araddr_reg;
   logic [3:0]         arid_reg;
   logic [CNT_W-1:0]   beat_cnt_reg;
   logic [31:0]        line_words_reg [LINE_BEATS];
   logic [LINE_BEATS*32-1:0] line_flat;
   logic               unused_rsp;

   // rid/rresp are deliberately not inspected
   assign unused_rsp = ^{axi.rid, axi.rresp};

   assign any_req = icache_rd_req | dcache_rd_req;

`ifdef REFILL_RR_ARB_EN
   // 1 = dcache was granted most recently
   logic last_grant_reg;

   always_ff @(posedge clk) begin
      if (!resetn)
         last_grant_reg <= 1'b0;
      else if (state_reg == IDLE && any_req)
         last_grant_reg <= grant_dcache;
   end

   always_comb begin
      grant_dcache = dcache_rd_req;
      if (icache_rd_req && dcache_rd_req)
         grant_dcache = ~last_grant_reg;
   end
`else
   always_comb begin
      grant_dcache = dcache_rd_req;
   end
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!resetn)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // next-state and handshake outputs
   always_comb begin
      state_next    = state_reg;
      axi.arvalid   = 1'b0;
      axi.rready    = 1'b0;
      icache_reload = 1'b0;
      dcache_reload = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_req)
               state_next = AR;
         end
         AR: begin
            axi.arvalid = 1'b1;
            if (axi.arready)
               state_next = R;
         end
         R: begin
            axi.rready = 1'b1;
            // rlast ends the burst even if fewer than LINE_BEATS beats arrived
            if (axi.rvalid && axi.rlast)
               state_next = DONE;
         end
         DONE: begin
            icache_reload = ~winner_dcache_reg;
            dcache_reload = winner_dcache_reg;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // request latch, beat counter and line buffer
   always_ff @(posedge clk) begin
      if (!resetn) begin
         winner_dcache_reg <= 1'b0;
         araddr_reg        <= 32'd0;
         arid_reg          <= 4'd0;
         beat_cnt_reg      <= '0;
         for (int i = 0; i < LINE_BEATS; i++)
            line_words_reg[i] <= 32'd0;
      end else begin
         if (state_reg == IDLE && any_req) begin
            winner_dcache_reg <= grant_dcache;
            araddr_reg        <= (grant_dcache ? dcache_rd_addr : icache_rd_addr) & LINE_MASK;
            arid_reg          <= grant_dcache ? DCACHE_ID : ICACHE_ID;
         end
         if (state_reg == AR && axi.arready)
            beat_cnt_reg <= '0;
         if (state_reg == R && axi.rvalid) begin
            line_words_reg[beat_cnt_reg] <= axi.rdata;
            beat_cnt_reg                 <= beat_cnt_reg + 1'b1;
         end
      end
   end

   // beat 0 lands in the least significant word
   generate
      for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_line
         assign line_flat[gi*32 +: 32] = line_words_reg[gi];
      end
   endgenerate

   assign icache_cacheline_new = line_flat;
   assign dcache_cacheline_new = line_flat;

   assign axi.araddr  = araddr_reg;
   assign axi.arid    = arid_reg;
   assign axi.arlen   = 8'(LINE_BEATS - 1);
   assign axi.arsize  = 3'b010;
   assign axi.arburst = 2'b01;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_arbiter
// Self-checking bench: a memory responder drives the AXI slave side, expected
// lines are queued when the final beat is driven and compared when a reload
// pulse appears.
// -----------------------------------------------------------------------------
module tb_cache_refill_arbiter;
   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         icache_rd_req = 1'b0;
   logic [31:0]  icache_rd_addr = 32'd0;
   logic         icache_reload;
   logic [511:0] icache_cacheline_new;
   logic         dcache_rd_req = 1'b0;
   logic [31:0]  dcache_rd_addr = 32'd0;
   logic         dcache_reload;
   logic [511:0] dcache_cacheline_new;

   cache_refill_arbiter_if axi();

   cache_refill_arbiter dut (
      .clk                  (clk),
      .resetn               (resetn),
      .icache_rd_req        (icache_rd_req),
      .icache_rd_addr       (icache_rd_addr),
      .icache_reload        (icache_reload),
      .icache_cacheline_new (icache_cacheline_new),
      .dcache_rd_req        (dcache_rd_req),
      .dcache_rd_addr       (dcache_rd_addr),
      .dcache_reload        (dcache_reload),
      .dcache_cacheline_new (dcache_cacheline_new),
      .axi                  (axi)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         is_dcache;
      logic [511:0] line;
   } exp_t;

   exp_t         exp_q[$];
   logic [511:0] model_line = '0;
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           reloads_seen = 0;
   int           reloads_expected = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard side: every reload pulse consumes one expected line
   always @(negedge clk) begin
      exp_t e;
      if (resetn && (icache_reload || dcache_reload)) begin
         reloads_seen++;
         if (exp_q.size() == 0) begin
            check_val("reload_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_val("reload_sel", {icache_reload, dcache_reload}, e.is_dcache ? 2'b01 : 2'b10);
            check_val("line", e.is_dcache ? dcache_cacheline_new : icache_cacheline_new, e.line);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_arvalid(output int t);
      int n = 0;
      while (axi.arvalid !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (axi.arvalid !== 1'b1) check_val("ar_timeout", 0, 1);
      t = cyc;
   endtask

   // Serve one burst from the memory side and confirm the reload cycle.
   task automatic serve(input logic is_d, input logic [31:0] req_addr, input int ar_delay,
                        input int gap, input int last_beat, input logic [31:0] dbase,
                        output int t_ar, output int t_rel);
      exp_t e;
      wait_arvalid(t_ar);
      check_val("araddr", axi.araddr, req_addr & 32'hFFFF_FFC0);
      check_val("arid", axi.arid, is_d ? 4'd1 : 4'd0);
      check_val("arlen", axi.arlen, 8'd15);
      check_val("arsize", axi.arsize, 3'd2);
      check_val("arburst", axi.arburst, 2'd1);
      for (int d = 0; d < ar_delay; d++) begin
         axi.arready = 1'b0;
         @(negedge clk);
         check_val("arvalid_hold", axi.arvalid, 1);
         check_val("araddr_hold", axi.araddr, req_addr & 32'hFFFF_FFC0);
         check_val("rready_early", axi.rready, 0);
      end
      axi.arready = 1'b1;
      @(negedge clk);
      axi.arready = 1'b0;
      for (int b = 0; b <= last_beat; b++) begin
         for (int g = 0; g < gap; g++) begin
            axi.rvalid = 1'b0;
            @(negedge clk);
         end
         check_val("rready", axi.rready, 1);
         axi.rvalid = 1'b1;
         axi.rdata  = dbase + 32'(b);
         axi.rlast  = (b == last_beat);
         axi.rid    = 4'($urandom_range(0, 15));
         axi.rresp  = 2'($urandom_range(0, 3));
         model_line[b*32 +: 32] = dbase + 32'(b);
         if (b == last_beat) begin
            e.is_dcache = is_d;
            e.line      = model_line;
            exp_q.push_back(e);
            reloads_expected++;
         end
         @(negedge clk);
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      check_val("reload_cycle", is_d ? dcache_reload : icache_reload, 1);
      t_rel = cyc;
      if (is_d) dcache_rd_req = 1'b0;
      else      icache_rd_req = 1'b0;
      $display("burst cache=%s addr=%h beats=%0d ar_delay=%0d gap=%0d",
               is_d ? "dcache" : "icache", req_addr & 32'hFFFF_FFC0, last_beat + 1, ar_delay, gap);
   endtask

   initial begin
      int t0, ta, tr;
      logic first_d;
      logic [511:0] prior;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rlast   = 1'b0;
      axi.rdata   = 32'd0;
      axi.rid     = 4'd0;
      axi.rresp   = 2'd0;

      // reset state
      repeat (3) @(negedge clk);
      check_val("rst_arvalid", axi.arvalid, 0);
      check_val("rst_rready", axi.rready, 0);
      check_val("rst_reload", {icache_reload, dcache_reload}, 2'b00);
      check_val("rst_araddr", axi.araddr, 0);
      check_val("rst_arid", axi.arid, 0);
      check_val("rst_line", icache_cacheline_new, 0);
      resetn = 1'b1;
      @(negedge clk);

      // single icache refill with latency checks
      icache_rd_addr = 32'h1FC0_0123;
      icache_rd_req  = 1'b1;
      t0 = cyc;
      serve(1'b0, 32'h1FC0_0123, 0, 0, 15, 32'd0, ta, tr);
      check_val("ar_latency", ta - t0, 1);
      check_val("reload_latency", tr - t0, 18);
      check_val("word0", icache_cacheline_new[31:0], 32'd0);
      check_val("word15", icache_cacheline_new[511:480], 32'd15);
      @(negedge clk);
      check_val("reload_off", {icache_reload, dcache_reload}, 2'b00);
      check_val("line_held", icache_cacheline_new[511:480], 32'd15);

      // both requests, icache granted last: dcache first in either build
      icache_rd_addr = 32'h0000_1040;
      dcache_rd_addr = 32'h8000_2044;
      icache_rd_req  = 1'b1;
      dcache_rd_req  = 1'b1;
      serve(1'b1, 32'h8000_2044, 0, 0, 15, 32'h100, ta, tr);
      serve(1'b0, 32'h0000_1040, 0, 0, 15, 32'h200, ta, tr);

      // dcache alone, then both: arbitration policy decides
      dcache_rd_addr = 32'h0000_3000;
      dcache_rd_req  = 1'b1;
      serve(1'b1, 32'h0000_3000, 0, 0, 15, 32'h300, ta, tr);
`ifdef REFILL_RR_ARB_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      icache_rd_addr = 32'h0000_4000;
      dcache_rd_addr = 32'h0000_5000;
      icache_rd_req  = 1'b1;
      dcache_rd_req  = 1'b1;
      serve(first_d, first_d ? 32'h0000_5000 : 32'h0000_4000, 0, 0, 15, 32'h380, ta, tr);
      serve(~first_d, first_d ? 32'h0000_4000 : 32'h0000_5000, 0, 0, 15, 32'h3C0, ta, tr);

      // arready held low for 3 cycles
      icache_rd_addr = 32'h0000_7080;
      icache_rd_req  = 1'b1;
      serve(1'b0, 32'h0000_7080, 3, 0, 15, 32'h400, ta, tr);

      // 2-cycle gaps between beats
      dcache_rd_addr = 32'hA000_00C4;
      dcache_rd_req  = 1'b1;
      serve(1'b1, 32'hA000_00C4, 0, 2, 15, 32'h500, ta, tr);

      // reset while beat 7 is on the bus
      icache_rd_addr = 32'h0000_6000;
      icache_rd_req  = 1'b1;
      wait_arvalid(ta);
      axi.arready = 1'b1;
      @(negedge clk);
      axi.arready = 1'b0;
      for (int b = 0; b < 7; b++) begin
         axi.rvalid = 1'b1;
         axi.rdata  = 32'hDEAD_0000 + 32'(b);
         @(negedge clk);
      end
      axi.rvalid = 1'b1;
      axi.rdata  = 32'hDEAD_0007;
      resetn     = 1'b0;
      @(negedge clk);
      axi.rvalid = 1'b0;
      check_val("abort_arvalid", axi.arvalid, 0);
      check_val("abort_rready", axi.rready, 0);
      check_val("abort_reload", {icache_reload, dcache_reload}, 2'b00);
      check_val("abort_line", dcache_cacheline_new, 0);
      $display("burst cache=icache addr=00006000 aborted by reset at beat 7");
      model_line = '0;
      resetn     = 1'b1;
      serve(1'b0, 32'h0000_6000, 0, 0, 15, 32'h600, ta, tr);

      // early rlast on beat 3: upper words keep the previous line
      prior          = model_line;
      dcache_rd_addr = 32'h0000_9000;
      dcache_rd_req  = 1'b1;
      serve(1'b1, 32'h0000_9000, 0, 0, 3, 32'h700, ta, tr);
      check_val("early_low", dcache_cacheline_new[127:0],
                {32'h703, 32'h702, 32'h701, 32'h700});
      check_val("early_keep", dcache_cacheline_new[511:128], prior[511:128]);

      repeat (4) @(negedge clk);
      check_val("reload_count", reloads_seen, reloads_expected);
      check_val("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
